clock_rate_scheduler: RTL and testbench

- Synchronous rate controller for the clock-division path: one clock domain produces a clock-enable tick and a registered square wave every 2^n cycles.
- The divide exponent n can be reprogrammed at runtime through a req/ack handshake.
- A new rate takes effect only on a period boundary, so downstream logic never sees a truncated or runt period.
- Replaces ripple-divided clocks with enables and keeps the design on a single clock.

---
 rtl/clock_rate_scheduler.sv | 170 +++++++++++++++++
 tb/tb_clock_rate_scheduler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_rate_scheduler.sv
// clock_rate_scheduler: single-clock rate controller that emits a tick and a
// 50% square wave every 2^n cycles. The exponent n can be reprogrammed at
// runtime through a req/ack handshake and changes only on period boundaries.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   enable     in   1 = run divider, 0 = idle
//   rate_sel   in   requested exponent n (clamped to MAX_N)
//   rate_req   in   rate-change request (level)
//   rate_ack   out  one-cycle pulse when the requested rate takes effect
//   busy       out  change accepted but not yet applied
//   active_sel out  exponent currently in force
//   tick       out  one-cycle pulse per period (during cnt=0 after a wrap)
//   div_out    out  registered square wave, period 2^n
module clock_rate_scheduler #(
  parameter int unsigned MAX_N     = 8,
  parameter int unsigned SEL_W     = 4,
  parameter int unsigned RESET_SEL = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [SEL_W-1:0] rate_sel,
  input  logic             rate_req,
  output logic             rate_ack,
  output logic             busy,
  output logic [SEL_W-1:0] active_sel,
  output logic             tick,
  output logic             div_out
);

  localparam int unsigned CW = MAX_N;
  localparam int unsigned MW = MAX_N + 1;

  typedef enum logic [1:0] {IDLE, RUN, PENDING} state_t;

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             tick_d, div_d, ack_d, busy_d;
  logic [SEL_W-1:0] active_d, pending, pending_d;

  logic [MW-1:0]    one_sh;
  logic [CW-1:0]    mask, half, cnt_nx;
  logic             wrap, div_nx, accept;
  logic [SEL_W-1:0] clamp_sel;

  // Period arithmetic for the exponent in force; half is 2^(n-1), or 0 for n=0.
  always_comb begin
    one_sh = MW'(1) << active_sel;
    mask   = CW'(one_sh - MW'(1));
    half   = mask ^ (mask >> 1);
    wrap   = (cnt == mask);
    cnt_nx = wrap ? '0 : cnt + CW'(1);
    div_nx = |(cnt_nx & half);
  end

  // Request acceptance and silent clamping of out-of-range exponents.
  always_comb begin
    accept    = rate_req && !rate_ack && !busy && (state != PENDING);
    clamp_sel = (rate_sel > SEL_W'(MAX_N)) ? SEL_W'(MAX_N) : rate_sel;
  end

  // Next-state and next-output logic.
  // busy outside PENDING means an IDLE-style change is due on the next edge.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    tick_d    = 1'b0;
    div_d     = div_out;
    ack_d     = 1'b0;
    busy_d    = busy;
    active_d  = active_sel;
    pending_d = pending;

    if (accept) pending_d = clamp_sel;

    case (state)
      IDLE: begin
        cnt_d = '0;
        div_d = 1'b0;
        if (busy) begin
          active_d = pending;
          ack_d    = 1'b1;
          busy_d   = 1'b0;
        end
        if (accept) busy_d = 1'b1;
        if (enable) state_d = RUN;
      end

      RUN: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
          div_d   = 1'b0;
          if (busy) begin
            active_d = pending;
            ack_d    = 1'b1;
            busy_d   = 1'b0;
          end
          if (accept) busy_d = 1'b1;
        end else if (busy) begin
          // Request accepted in IDLE on the edge we started: restart the period at the new rate.
          active_d = pending;
          ack_d    = 1'b1;
          busy_d   = 1'b0;
          cnt_d    = '0;
          div_d    = 1'b0;
        end else begin
          cnt_d  = cnt_nx;
          tick_d = wrap;
          div_d  = div_nx;
          if (accept) begin
            state_d = PENDING;
            busy_d  = 1'b1;
          end
        end
      end

      PENDING: begin
        if (!enable) begin
          state_d  = IDLE;
          cnt_d    = '0;
          div_d    = 1'b0;
          active_d = pending;
          ack_d    = 1'b1;
          busy_d   = 1'b0;
        end else begin
          cnt_d  = cnt_nx;
          tick_d = wrap;
          div_d  = div_nx;
          if (wrap) begin
            // Old period has just completed; the new rate starts at cnt=0.
            state_d  = RUN;
            active_d = pending;
            div_d    = 1'b0;
            ack_d    = 1'b1;
            busy_d   = 1'b0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      tick       <= 1'b0;
      div_out    <= 1'b0;
      rate_ack   <= 1'b0;
      busy       <= 1'b0;
      active_sel <= SEL_W'(RESET_SEL);
      pending    <= SEL_W'(RESET_SEL);
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      tick       <= tick_d;
      div_out    <= div_d;
      rate_ack   <= ack_d;
      busy       <= busy_d;
      active_sel <= active_d;
      pending    <= pending_d;
    end
  end

endmodule

// File: tb/tb_clock_rate_scheduler.sv
// tb_clock_rate_scheduler: directed bench for clock_rate_scheduler. Expected
// per-cycle outputs are queued as stimulus is applied and compared one entry
// per clock, sampled 1 time unit after the rising edge.
module tb_clock_rate_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] rate_sel;
  logic       rate_req;
  logic       rate_ack;
  logic       busy;
  logic [3:0] active_sel;
  logic       tick;
  logic       div_out;

  clock_rate_scheduler #(.MAX_N(8), .SEL_W(4), .RESET_SEL(1)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .rate_sel   (rate_sel),
    .rate_req   (rate_req),
    .rate_ack   (rate_ack),
    .busy       (busy),
    .active_sel (active_sel),
    .tick       (tick),
    .div_out    (div_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       tick;
    logic       div;
    logic       ack;
    logic       busy;
    logic [3:0] sel;
  } exp_t;

  exp_t  sb[$];
  int    n_assert = 0;
  int    n_fail   = 0;
  int    m_cnt    = 0;
  string cur_tag  = "init";

  task automatic push(input logic t, input logic d, input logic a, input logic b, input logic [3:0] s);
    exp_t e;
    e.tick = t; e.div = d; e.ack = a; e.busy = b; e.sel = s;
    sb.push_back(e);
  endtask

  task automatic cmp(input string name, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: observed %0h expected %0h", cur_tag, name, obs, exp);
    end
  endtask

  // One clock: pop the oldest expectation and compare every output.
  task automatic check_cycle();
    exp_t e;
    @(posedge clock);
    #1;
    n_assert++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL %s/scoreboard: observed empty queue expected entry", cur_tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cmp("tick",       4'(tick),     4'(e.tick));
      cmp("div_out",    4'(div_out),  4'(e.div));
      cmp("rate_ack",   4'(rate_ack), 4'(e.ack));
      cmp("busy",       4'(busy),     4'(e.busy));
      cmp("active_sel", active_sel,   e.sel);
    end
  endtask

  task automatic drain();
    while (sb.size() > 0) check_cycle();
  endtask

  // Expected outputs for running edges at exponent n, continuing from m_cnt.
  task automatic push_run(input int n, input int cycles, input logic b, input logic [3:0] s);
    int   top;
    logic t;
    logic d;
    top = (1 << n) - 1;
    for (int i = 0; i < cycles; i++) begin
      t     = (m_cnt == top);
      m_cnt = t ? 0 : m_cnt + 1;
      d     = (n > 0) && (m_cnt >= (1 << (n - 1)));
      push(t, d, 1'b0, b, s);
    end
  endtask

  // Rate change from IDLE: accept edge, then ack edge, then quiet edge.
  task automatic idle_set(input logic [3:0] sel_in, input logic [3:0] old_sel, input logic [3:0] new_sel);
    rate_sel = sel_in;
    rate_req = 1'b1;
    push(1'b0, 1'b0, 1'b0, 1'b1, old_sel);
    check_cycle();
    rate_req = 1'b0;
    push(1'b0, 1'b0, 1'b1, 1'b0, new_sel);
    check_cycle();
    push(1'b0, 1'b0, 1'b0, 1'b0, new_sel);
    check_cycle();
  endtask

  task automatic enter_run(input logic [3:0] s);
    enable = 1'b1;
    push(1'b0, 1'b0, 1'b0, 1'b0, s);
    check_cycle();
    m_cnt = 0;
  endtask

  task automatic go_idle(input logic [3:0] s);
    enable = 1'b0;
    push(1'b0, 1'b0, 1'b0, 1'b0, s);
    check_cycle();
    m_cnt = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    rate_sel = 4'd0;
    rate_req = 1'b0;

    cur_tag = "reset";
    push(1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
    check_cycle();

    // Run at the reset exponent n=1.
    cur_tag = "run_n1";
    reset = 1'b0;
    enter_run(4'd1);
    push_run(1, 8, 1'b0, 4'd1);
    drain();
    go_idle(4'd1);

    // IDLE rate change to n=3, then run.
    cur_tag = "idle_set_n3";
    idle_set(4'd3, 4'd1, 4'd3);
    enter_run(4'd3);
    push_run(3, 20, 1'b0, 4'd3);
    drain();
    go_idle(4'd3);

    // Running n=4, request n=2 at cnt=5: old period completes first.
    cur_tag = "pend_4_to_2";
    idle_set(4'd4, 4'd3, 4'd4);
    enter_run(4'd4);
    push_run(4, 5, 1'b0, 4'd4);
    drain();
    rate_sel = 4'd2;
    rate_req = 1'b1;
    push_run(4, 1, 1'b1, 4'd4);
    check_cycle();
    rate_req = 1'b0;
    push_run(4, 9, 1'b1, 4'd4);
    drain();
    push(1'b1, 1'b0, 1'b1, 1'b0, 4'd2);
    check_cycle();
    m_cnt = 0;
    push_run(2, 12, 1'b0, 4'd2);
    drain();
    go_idle(4'd2);

    // Out-of-range request clamps to MAX_N=8, period 256.
    cur_tag = "clamp_12";
    idle_set(4'd12, 4'd2, 4'd8);
    enter_run(4'd8);
    push_run(8, 520, 1'b0, 4'd8);
    drain();
    go_idle(4'd8);

    // PENDING n=3 -> 1, drop enable at cnt=2: change applied going idle.
    cur_tag = "pend_drop_enable";
    idle_set(4'd3, 4'd8, 4'd3);
    enter_run(4'd3);
    rate_sel = 4'd1;
    rate_req = 1'b1;
    push_run(3, 1, 1'b1, 4'd3);
    check_cycle();
    rate_req = 1'b0;
    push_run(3, 1, 1'b1, 4'd3);
    check_cycle();
    enable = 1'b0;
    push(1'b0, 1'b0, 1'b1, 1'b0, 4'd1);
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
    drain();
    m_cnt = 0;

    // n=0: tick every running cycle after the first, div_out stays low.
    cur_tag = "run_n0";
    idle_set(4'd0, 4'd1, 4'd0);
    enter_run(4'd0);
    push_run(0, 4, 1'b0, 4'd0);
    drain();
    go_idle(4'd0);

    // Reset while PENDING at cnt=6 discards the change without an ack.
    cur_tag = "reset_in_pend";
    idle_set(4'd3, 4'd0, 4'd3);
    enter_run(4'd3);
    push_run(3, 4, 1'b0, 4'd3);
    drain();
    rate_sel = 4'd5;
    rate_req = 1'b1;
    push_run(3, 1, 1'b1, 4'd3);
    check_cycle();
    rate_req = 1'b0;
    push_run(3, 1, 1'b1, 4'd3);
    check_cycle();
    reset  = 1'b1;
    enable = 1'b0;
    push(1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
    check_cycle();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
